// File: rtl/jram_reader.sv
// Sequential read-out engine for the 256x8 jRAM: walks an address range, strobes SA/E and
// presents each byte on a valid/ready port. Optional checksum: JRAM_READER_CHECKSUM_EN.
module jram_reader #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [7:0]  END_ADDR   = 8'hFF,
  parameter int unsigned EN_CYCLES  = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] ram_addr,
  output logic       ram_sa,
  output logic       ram_e,
  input  logic [7:0] ram_data,
  output logic [7:0] out_addr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
`ifdef JRAM_READER_CHECKSUM_EN
  ,
  output logic [7:0] csum,
  output logic       csum_valid
`endif
);

  localparam int unsigned CntW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(EN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSeta, StEna, StHold, StFin} state_e;

  state_e          state_q, state_d;
  logic [7:0]      ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      ram_addr_q, ram_addr_d;
  logic [7:0]      out_addr_q, out_addr_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            ram_sa_q, ram_sa_d;
  logic            ram_e_q, ram_e_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    xfer        = (state_q == StHold) && out_valid_q && out_ready;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d   = START_ADDR;
          state_d = StSeta;
        end
      end
      StSeta: begin
        cnt_d   = '0;
        state_d = StEna;
      end
      StEna: begin
        if (cnt_q == CntLast) begin
          out_data_d  = ram_data;
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          if (ptr_q == END_ADDR) begin
            state_d = StFin;
          end else begin
            ptr_d   = ptr_q + 8'd1;
            state_d = StSeta;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a capture or handshake on the same edge.
    if (abort) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end

    if (state_d == StSeta) ram_addr_d = ptr_d;

    // Strobes are decoded from the next state so they come straight out of flops.
    ram_sa_d = (state_d == StSeta);
    ram_e_d  = (state_d == StEna);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StFin);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= StIdle;
      ptr_q       <= START_ADDR;
      cnt_q       <= '0;
      ram_addr_q  <= 8'h00;
      out_addr_q  <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ram_sa_q    <= 1'b0;
      ram_e_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ram_sa_q    <= ram_sa_d;
      ram_e_q     <= ram_e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_sa    = ram_sa_q;
  assign ram_e     = ram_e_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef JRAM_READER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_valid_q;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == StIdle) && start && !abort) begin
      csum_d = 8'h00;
    end else if (xfer) begin
      csum_d = csum_q + out_data_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      csum_q       <= 8'h00;
      csum_valid_q <= 1'b0;
    end else begin
      csum_q       <= csum_d;
      csum_valid_q <= done_d;
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
`endif

endmodule

// File: tb/tb_jram_reader.sv
// Scoreboard bench for jram_reader: default-range instance (A) and a wrapping, EN_CYCLES=3
// instance (B), each with a small jRAM model behind the SA/E strobes.
module tb_jram_reader;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic       a_start, a_abort, a_ram_sa, a_ram_e, a_out_valid, a_out_ready, a_busy, a_done;
  logic [7:0] a_ram_addr, a_ram_data, a_out_addr, a_out_data;
  logic       b_start, b_abort, b_ram_sa, b_ram_e, b_out_valid, b_out_ready, b_busy, b_done;
  logic [7:0] b_ram_addr, b_ram_data, b_out_addr, b_out_data;
`ifdef JRAM_READER_CHECKSUM_EN
  logic [7:0] a_csum, b_csum;
  logic       a_csum_valid, b_csum_valid;
`endif

  jram_reader u_a (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .start     (a_start),
    .abort     (a_abort),
    .ram_addr  (a_ram_addr),
    .ram_sa    (a_ram_sa),
    .ram_e     (a_ram_e),
    .ram_data  (a_ram_data),
    .out_addr  (a_out_addr),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .busy      (a_busy),
    .done      (a_done)
`ifdef JRAM_READER_CHECKSUM_EN
    ,
    .csum      (a_csum),
    .csum_valid(a_csum_valid)
`endif
  );

  jram_reader #(
    .START_ADDR(8'hFE),
    .END_ADDR  (8'h01),
    .EN_CYCLES (3)
  ) u_b (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .start     (b_start),
    .abort     (b_abort),
    .ram_addr  (b_ram_addr),
    .ram_sa    (b_ram_sa),
    .ram_e     (b_ram_e),
    .ram_data  (b_ram_data),
    .out_addr  (b_out_addr),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .busy      (b_busy),
    .done      (b_done)
`ifdef JRAM_READER_CHECKSUM_EN
    ,
    .csum      (b_csum),
    .csum_valid(b_csum_valid)
`endif
  );

  // jRAM models: address register loads on SA, data driven only while E is high.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] areg_a = 8'h00;
  logic [7:0] areg_b = 8'h00;
  always @(posedge CLK) if (a_ram_sa) areg_a <= a_ram_addr;
  always @(posedge CLK) if (b_ram_sa) areg_b <= b_ram_addr;
  assign a_ram_data = a_ram_e ? mem_a[areg_a] : 8'h00;
  assign b_ram_data = b_ram_e ? mem_b[areg_b] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          a_done_cnt = 0;
  int          b_done_cnt = 0;
  int unsigned a_last_hs = 0;
  int unsigned b_last_hs = 0;
  bit          b_have_hs = 1'b0;

  // Monitor: pops expected bytes on every handshake and checks done timing.
  always @(negedge CLK) begin
    logic [15:0] e;
    chk("a_sa_e_exclusive", {31'd0, a_ram_sa & a_ram_e}, 32'd0);
    chk("b_sa_e_exclusive", {31'd0, b_ram_sa & b_ram_e}, 32'd0);
    if (RESETN && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_byte: got addr %0h data %0h, none expected",
                 a_out_addr, a_out_data);
      end else begin
        e = qa.pop_front();
        chk("a_byte", {16'd0, a_out_addr, a_out_data}, {16'd0, e});
      end
      a_last_hs = cyc;
    end
    if (RESETN && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_byte: got addr %0h data %0h, none expected",
                 b_out_addr, b_out_data);
      end else begin
        e = qb.pop_front();
        chk("b_byte", {16'd0, b_out_addr, b_out_data}, {16'd0, e});
      end
      if (b_have_hs) chk("b_byte_interval", cyc - b_last_hs, 32'd5);
      b_have_hs = 1'b1;
      b_last_hs = cyc;
    end
    if (a_done) begin
      a_done_cnt++;
      chk("a_done_latency", cyc - a_last_hs, 32'd1);
      chk("a_done_queue_empty", qa.size(), 32'd0);
    end
    if (b_done) begin
      b_done_cnt++;
      b_have_hs = 1'b0;
      chk("b_done_latency", cyc - b_last_hs, 32'd1);
      chk("b_done_queue_empty", qb.size(), 32'd0);
    end
  end

  initial begin
    int unsigned t0;
    logic [7:0]  ad;
    for (int i = 0; i < 256; i++) begin
      ad = 8'(i);
      mem_a[i] = ad ^ 8'h5A;
      mem_b[i] = ad + 8'h33;
    end
    a_start = 0; a_abort = 0; a_out_ready = 1;
    b_start = 0; b_abort = 0; b_out_ready = 1;

    // Reset and idle
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("a_idle_outputs", {a_ram_addr, a_ram_sa, a_ram_e, a_out_addr, a_out_data, a_out_valid,
                           a_busy, a_done}, 32'd0);
    chk("b_idle_outputs", {b_ram_addr, b_ram_sa, b_ram_e, b_out_addr, b_out_data, b_out_valid,
                           b_busy, b_done}, 32'd0);

    // Asynchronous reset in the middle of ENA
    @(posedge CLK); #1 a_start = 1;
    @(posedge CLK); #1 a_start = 0;
    @(posedge CLK); #1 chk("a_in_ena", {31'd0, a_ram_e}, 32'd1);
    RESETN = 1'b0;
    #1 chk("a_async_reset", {a_ram_addr, a_ram_sa, a_ram_e, a_out_addr, a_out_data, a_out_valid,
                             a_busy, a_done}, 32'd0);
    @(posedge CLK); #1 RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("a_post_reset_idle", {a_ram_addr, a_ram_sa, a_ram_e, a_out_addr, a_out_data,
                              a_out_valid, a_busy, a_done}, 32'd0);

    // Full default scan with a stall at address 5
    for (int i = 0; i < 256; i++) begin
      ad = 8'(i);
      qa.push_back({ad, ad ^ 8'h5A});
    end
    @(posedge CLK); #1 a_start = 1; t0 = cyc + 1;
    @(posedge CLK); #1 a_start = 0;
    chk("a_busy_after_start", {31'd0, a_busy}, 32'd1);
    for (int i = 0; i < 100 && !(a_ram_sa && a_ram_addr == 8'd5); i++) @(negedge CLK);
    chk("a_reach_seta5", {31'd0, a_ram_sa && a_ram_addr == 8'd5}, 32'd1);
    a_out_ready = 0;
    for (int i = 0; i < 20 && !a_out_valid; i++) @(negedge CLK);
    chk("a_hold5_valid", {31'd0, a_out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("a_stall_stable", {13'd0, a_out_valid, a_out_addr, a_out_data, a_ram_sa, a_ram_e},
          {13'd0, 1'b1, 8'd5, 8'h5F, 2'b00});
    end
    @(posedge CLK); #1 a_out_ready = 1;
    for (int i = 0; i < 3000 && !a_done; i++) @(negedge CLK);
    chk("a_done_seen", {31'd0, a_done}, 32'd1);
    chk("a_scan_cycles", cyc - t0, 32'd1035);
`ifdef JRAM_READER_CHECKSUM_EN
    chk("a_csum", {24'd0, a_csum}, 32'h80);
    chk("a_csum_valid", {31'd0, a_csum_valid}, 32'd1);
`endif
    @(negedge CLK);
    chk("a_busy_drop", {30'd0, a_busy, a_done}, 32'd0);

    // Wrapping range on B, with a start pulse while busy that must be ignored
    qb.push_back({8'hFE, 8'h31});
    qb.push_back({8'hFF, 8'h32});
    qb.push_back({8'h00, 8'h33});
    qb.push_back({8'h01, 8'h34});
    b_have_hs = 1'b0;
    @(posedge CLK); #1 b_start = 1; t0 = cyc + 1;
    @(posedge CLK); #1 b_start = 0;
    @(posedge CLK); #1 b_start = 1;
    @(posedge CLK); #1 b_start = 0;
    for (int i = 0; i < 50 && !b_out_valid; i++) @(negedge CLK);
    chk("b_first_latency", cyc - t0, 32'd4);
    for (int i = 0; i < 100 && !b_done; i++) @(negedge CLK);
    chk("b_done_seen", {31'd0, b_done}, 32'd1);
    @(negedge CLK);
    chk("b_busy_drop", {31'd0, b_busy}, 32'd0);

    // Abort in the third ENA cycle
    @(posedge CLK); #1 b_start = 1;
    @(posedge CLK); #1 b_start = 0;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1 chk("b_ena3", {31'd0, b_ram_e}, 32'd1);
    b_abort = 1;
    @(posedge CLK); #1 b_abort = 0;
    chk("b_abort_idle", {27'd0, b_busy, b_ram_sa, b_ram_e, b_out_valid, b_done}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("b_abort_stays_idle", {30'd0, b_busy, b_done}, 32'd0);

    // Restart after abort begins again at START_ADDR
    qb.push_back({8'hFE, 8'h31});
    qb.push_back({8'hFF, 8'h32});
    qb.push_back({8'h00, 8'h33});
    qb.push_back({8'h01, 8'h34});
    b_have_hs = 1'b0;
    @(posedge CLK); #1 b_start = 1;
    @(posedge CLK); #1 b_start = 0;
    for (int i = 0; i < 100 && !b_done; i++) @(negedge CLK);
    chk("b_restart_done", {31'd0, b_done}, 32'd1);

    // start and abort together in IDLE: abort wins
    @(posedge CLK); #1 b_start = 1; b_abort = 1;
    @(posedge CLK); #1 b_start = 0; b_abort = 0;
    @(negedge CLK);
    chk("b_start_abort_idle", {30'd0, b_busy, b_ram_sa}, 32'd0);
    repeat (4) @(negedge CLK);

    chk("a_done_count", a_done_cnt, 32'd1);
    chk("b_done_count", b_done_cnt, 32'd2);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
